// File: rtl/dcache_pkg.sv
// Shared types and geometry for the MEM-stage data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_e;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 256;
    localparam int WORDS_PER_LINE = 8;
    localparam int OFF_W          = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_LSB     = 2;
    localparam int INDEX_LSB      = 5;

endpackage

// File: rtl/dcache_if.sv
// Off-chip data-memory req/ack bus: one line per transfer.
interface dcache_if;
    import dcache_pkg::*;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [LINE_W-1:0]     mem_wdata_o;
    logic [LINE_W-1:0]     mem_rdata_i;
    logic                  mem_ack_i;

    // cache controller side
    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    // memory side
    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/dirty flags, tags and data.
// One combinational read port and one write port sharing the same index.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    localparam int IDX_W    = $clog2(NUM_LINES),
    localparam int TAG_W    = ADDR_W - INDEX_LSB - IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              word_we_i,
    input  logic [OFF_W-1:0]  word_off_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  line_tag_i,
    input  logic [LINE_W-1:0] line_i
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [LINE_W-1:0]    data_mem [NUM_LINES];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

    // A refill installs a clean valid line; a store dirties the line it hits.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end else if (word_we_i) begin
            dirty_d[idx_i] = 1'b1;
        end
    end

    // Flag registers; reset invalidates every line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data storage is left unreset; valid gates its use.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            data_mem[idx_i] <= line_i;
            tag_mem[idx_i]  <= line_tag_i;
        end else if (word_we_i) begin
            data_mem[idx_i][word_off_i*WORD_W +: WORD_W] <= word_i;
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_mem[idx_i];
    assign rd_line_o  = data_mem[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data-cache controller: hit logic, miss FSM and registered
// memory-bus outputs. Write-back, write-allocate, direct-mapped.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              stall_o,
    dcache_if.master          mem
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - INDEX_LSB - IDX_W;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [OFF_W-1:0]    off;
    logic                access, hit, ack;
    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic                word_we, line_we;
    logic                unused_byte_bits;

    assign idx    = addr_i[INDEX_LSB +: IDX_W];
    assign tag    = addr_i[ADDR_W-1 -: TAG_W];
    assign off    = addr_i[OFFSET_LSB +: OFF_W];
    assign access = MemRead_i | MemWrite_i;
    assign hit    = rd_valid & (rd_tag == tag);
    // Acks only count while a request is actually outstanding.
    assign ack    = mem.mem_ack_i & mem_req_q;
    // Word-only accesses: byte-lane bits carry no meaning here.
    assign unused_byte_bits = ^addr_i[OFFSET_LSB-1:0];

    dcache_array #(.NUM_LINES(NUM_LINES)) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .word_we_i  (word_we),
        .word_off_i (off),
        .word_i     (wdata_i),
        .line_we_i  (line_we),
        .line_tag_i (tag),
        .line_i     (mem.mem_rdata_i)
    );

    // State and memory-bus registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Miss handling: dirty victims go out before the refill comes in.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (access && !hit)
                             state_d = (rd_valid && rd_dirty) ? S_WRITEBACK : S_REFILL;
            S_WRITEBACK: if (ack) state_d = S_REFILL;
            S_REFILL:    if (ack) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Pipeline-facing outputs, array writes, and bus values latched on state entry.
    always_comb begin
        stall_o     = (state_q != S_IDLE) | (access & ~hit);
        rdata_o     = (MemRead_i && hit) ? rd_line[off*WORD_W +: WORD_W] : '0;
        word_we     = (state_q == S_IDLE) & MemWrite_i & hit;
        line_we     = (state_q == S_REFILL) & ack;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d != state_q) begin
            unique case (state_d)
                S_WRITEBACK: begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {rd_tag, idx, 5'b0};
                    mem_wdata_d = rd_line;
                end
                S_REFILL: begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {tag, idx, 5'b0};
                end
                default: begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req_o   = mem_req_q;
    assign mem.mem_we_o    = mem_we_q;
    assign mem.mem_addr_o  = mem_addr_q;
    assign mem.mem_wdata_o = mem_wdata_q;

endmodule
